coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

Parametrised memory controller and snoop-bus arbiter for an NCPU-core system with private L1 I/D caches over one shared RAM port. Arbitrates instruction fetches, data block reads (BusRd/BusRdX) and dirty write-backs from every core round-robin. Broadcasts snoops to all other cores and forwards a Modified block cache-to-cache while writing it back to RAM. Sits between the per-core cache pairs and the RAM model, replacing the fixed two-core, two-word controller.

## Interface
- NCPU, 2: number of cores (2..8).
- WORDS, 2: 32-bit words per D-cache block (power of two, 1..16).
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  NCPU  per-core instruction read request (level, held until iwait low).
- iaddr  in  NCPU x 32  instruction word address.
- dREN, dWEN  in  NCPU each  data block read / write-back request (level, held until final word).
- daddr, dstore  in  NCPU x 32 each  data address / store word (core presents word k on the cycle after word k-1 is accepted).
- cctrans, ccwrite  in  NCPU each  cctrans on a requester: coherence miss; with ccwrite it is BusRdX. cctrans on a snooped core: it holds the block Modified and will flush.
- iwait, dwait  out  NCPU each  low for exactly one cycle per accepted word.
- iload, dload  out  NCPU x 32 each  returned data.
- ccwait, ccinv  out  NCPU each  snoop stall; invalidate.
- ccsnoopaddr  out  NCPU x 32  snoop address.
- ramREN, ramWEN  out  1 each.  ramaddr, ramstore  out  32 each.
- ramload  in  32.  ramstate  in  2  FREE/BUSY/ACCESS/ERROR (cpu_types_pkg).

## Operation
- States: IDLE, SNOOP, SNOOPWAIT, FLUSH, RAMRD, RAMWR, IFETCH.
- IDLE: scan cores from rr_ptr upward, wrapping modulo NCPU. The first core with any request is the owner, latched with its request class. Per-core class priority: dWEN > dREN > iREN. Next state: dWEN -> RAMWR, dREN -> SNOOP, iREN -> IFETCH. No request: stay.
- Block base = daddr[owner] with low log2(WORDS)+2 bits cleared. Word k address = base + 4k.
- Word counter wcnt, width max(1,log2(WORDS)): cleared on entry to FLUSH/RAMRD/RAMWR. It increments on each ramstate==ACCESS, and the state exits when wcnt==WORDS-1 is accepted.
- SNOOP (1 cycle): for every core j != owner, drive ccwait[j]=1 and ccsnoopaddr[j]=base. ccinv[j]=ccwrite[owner].
- SNOOPWAIT (1 cycle): same outputs. Sample cctrans[j] for j != owner. Responder = lowest-index asserting core, latched. Any responder -> FLUSH, else RAMRD.
- FLUSH: ramWEN=1, ramaddr=word k, ramstore=dstore[resp] and dload[owner]=dstore[resp]. ccsnoopaddr[resp]=word k. On ACCESS, dwait[owner]=dwait[resp]=0.
- RAMRD: ramREN=1, ramaddr=word k, dload[owner]=ramload. On ACCESS, dwait[owner]=0.
- RAMWR: ramWEN=1, ramaddr=word k, ramstore=dstore[owner]. On ACCESS, dwait[owner]=0.
- IFETCH: ramREN=1, ramaddr=iaddr[owner], iload[owner]=ramload. On ACCESS, iwait[owner]=0; single word.
- In SNOOP, SNOOPWAIT, FLUSH and RAMRD, ccwait/ccinv/ccsnoopaddr stay driven to all non-owner cores.
- On the last accepted word: state -> IDLE, rr_ptr <= (owner+1) mod NCPU.
- ramstate ERROR/FREE/BUSY: hold state, counter and outputs. No timeout.

## Timing
- Reset (async, RST=1): state IDLE, rr_ptr=0, wcnt=0.
- Reset output values: iwait/dwait all 1; ccwait/ccinv 0; ccsnoopaddr, iload, dload, ramaddr, ramstore 0; ramREN/ramWEN 0.
- Reset mid-transaction aborts immediately with no further RAM strobes; requesters re-issue.
- Outputs are combinational from registered state, owner, responder and wcnt; ramstate drives wait lines combinationally.
- Latency, zero-wait RAM (ACCESS on the first strobe cycle):
  - IFETCH: 2 cycles from request to iwait low.
  - Block read: 1 arbitration cycle + 2 snoop cycles + WORDS data cycles.
  - Write-back: 1 + WORDS cycles.
- Requests arriving while a transaction is in progress wait. The owner's next request is arbitrated only after the other cores are scanned (rr_ptr advance).
- Simultaneous requests from all cores are served in order rr_ptr, rr_ptr+1, …; no core is starved beyond NCPU-1 transactions.

## Test plan
- NCPU=4, WORDS=4, RAM always ACCESS. Core2 iREN, iaddr=0x100 -> IFETCH, ramaddr=0x100, iwait[2] low 2 cycles after request. rr_ptr=3 afterwards.
- Cores 0,1,3 all dREN with no responders, rr_ptr=0 -> service order 0,1,3. Each gets 4 dwait pulses with ramaddr base..base+12.
- Core1 dREN+cctrans+ccwrite at 0x2A4, core3 responds cctrans=1:
  - ccinv[0,2,3]=1 and ccsnoopaddr=0x2A0.
  - FLUSH writes dstore[3] to 0x2A0..0x2AC.
  - dload[1]=dstore[3].
  - dwait[1] and dwait[3] pulse together 4 times.
- Cores 0 and 2 both respond to core1's snoop -> responder is core 0 only. dwait[2] stays high.
- Core0 dWEN at 0x40, ramstate alternating BUSY/ACCESS -> 4 words 0x40..0x4C, one word per ACCESS, counter held during BUSY.
- RST asserted during FLUSH word 2 -> same cycle: ramWEN=0, all dwait=1, ccwait=0. After release, the re-issued request restarts at word 0.

Source files
------------

// File: rtl/coherence_bus_ctrl_if.sv
// coherence_bus_ctrl_if: per-core cache request/snoop lines and the shared RAM port
// Ports (slave = controller side, master = caches + RAM side):
//   iREN/iaddr, dREN/dWEN/daddr/dstore, cctrans/ccwrite  : core requests and snoop replies
//   iwait/iload, dwait/dload                             : per-word handshake and returned data
//   ccwait/ccinv/ccsnoopaddr                             : snoop broadcast to non-owning cores
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate     : single shared RAM port
interface coherence_bus_ctrl_if #(parameter int NCPU = 2);
  logic [NCPU-1:0] iREN, dREN, dWEN, cctrans, ccwrite;
  logic [NCPU-1:0] iwait, dwait, ccwait, ccinv;
  logic [NCPU-1:0][31:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate;
  modport slave (
    input iREN, dREN, dWEN, cctrans, ccwrite, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, ccwait, ccinv, iload, dload, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, dREN, dWEN, cctrans, ccwrite, iaddr, daddr, dstore, ramload, ramstate,
    input iwait, dwait, ccwait, ccinv, iload, dload, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: round-robin memory controller and snoop-bus arbiter for NCPU cores
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : coherence_bus_ctrl_if.slave carrying core requests, snoop lines and the RAM port
module coherence_bus_ctrl #(
  parameter int NCPU = 2,
  parameter int WORDS = 2
) (
  input logic CLK,
  input logic RST,
  coherence_bus_ctrl_if.slave bus
);
  localparam int OW = $clog2(NCPU);
  localparam int WB = $clog2(WORDS);
  localparam int WW = WB > 0 ? WB : 1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [31:0] BMASK = ~((32'd1 << (WB + 2)) - 32'd1);
  typedef enum logic [2:0] {IDLE, SNOOP, SNOOPWAIT, FLUSH, RAMRD, RAMWR, IFETCH} state_t;
  state_t state, nxt;
  logic [OW-1:0] owner, resp, rr_ptr, sel, rsel, idx;
  logic [WW-1:0] wcnt;
  logic found, rfound, acc, blk, snp, last;
  logic [31:0] base, waddr;
  assign acc = bus.ramstate == ACCESS;
  assign blk = state inside {FLUSH, RAMRD, RAMWR};
  assign snp = state inside {SNOOP, SNOOPWAIT, FLUSH, RAMRD};
  assign last = acc && (state == IFETCH || (blk && wcnt == WW'(WORDS - 1)));
  assign base = bus.daddr[owner] & BMASK;
  assign waddr = base + (32'(wcnt) << 2);
  // Scan from rr_ptr with wraparound for the next owner; responder is the lowest non-owner flushing core
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    rfound = 1'b0;
    rsel = '0;
    for (int i = 0; i < NCPU; i++) begin
      idx = OW'((int'(rr_ptr) + i) % NCPU);
      if (!found && (bus.iREN[idx] || bus.dREN[idx] || bus.dWEN[idx])) begin
        found = 1'b1;
        sel = idx;
      end
    end
    for (int j = 0; j < NCPU; j++) begin
      if (!rfound && j != int'(owner) && bus.cctrans[j]) begin
        rfound = 1'b1;
        rsel = OW'(j);
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !found ? IDLE : bus.dWEN[sel] ? RAMWR : bus.dREN[sel] ? SNOOP : IFETCH;
      SNOOP: nxt = SNOOPWAIT;
      SNOOPWAIT: nxt = rfound ? FLUSH : RAMRD;
      default: nxt = last ? IDLE : state;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      resp <= '0;
      rr_ptr <= '0;
      wcnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) owner <= sel;
      if (state == SNOOPWAIT) resp <= rsel;
      // any state change clears the counter, so every data phase starts at word 0
      if (nxt != state) wcnt <= '0;
      else if (acc && blk) wcnt <= wcnt + 1'b1;
      if (last) rr_ptr <= owner == OW'(NCPU - 1) ? '0 : owner + 1'b1;
    end
  end
  always_comb begin
    bus.iwait = '1;
    bus.dwait = '1;
    bus.ccwait = '0;
    bus.ccinv = '0;
    bus.ccsnoopaddr = '0;
    bus.iload = '0;
    bus.dload = '0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.ramaddr = '0;
    bus.ramstore = '0;
    if (snp) begin
      for (int j = 0; j < NCPU; j++) begin
        if (j != int'(owner)) begin
          bus.ccwait[j] = 1'b1;
          bus.ccinv[j] = bus.ccwrite[owner];
          bus.ccsnoopaddr[j] = base;
        end
      end
    end
    case (state)
      FLUSH: begin
        // Modified block goes to RAM and straight to the requester in the same beat
        bus.ramWEN = 1'b1;
        bus.ramaddr = waddr;
        bus.ramstore = bus.dstore[resp];
        bus.dload[owner] = bus.dstore[resp];
        bus.ccsnoopaddr[resp] = waddr;
        bus.dwait[owner] = !acc;
        bus.dwait[resp] = !acc;
      end
      RAMRD: begin
        bus.ramREN = 1'b1;
        bus.ramaddr = waddr;
        bus.dload[owner] = bus.ramload;
        bus.dwait[owner] = !acc;
      end
      RAMWR: begin
        bus.ramWEN = 1'b1;
        bus.ramaddr = waddr;
        bus.ramstore = bus.dstore[owner];
        bus.dwait[owner] = !acc;
      end
      IFETCH: begin
        bus.ramREN = 1'b1;
        bus.ramaddr = bus.iaddr[owner];
        bus.iload[owner] = bus.ramload;
        bus.iwait[owner] = !acc;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: scoreboard bench for the 4-core, 4-word coherence controller
module tb_coherence_bus_ctrl;
  localparam int N = 4;
  localparam int W = 4;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  typedef struct {int core; logic [31:0] addr; logic [31:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int acc [N];
  exp_t exp_q [$];
  coherence_bus_ctrl_if #(.NCPU(N)) bus ();
  coherence_bus_ctrl #(.NCPU(N), .WORDS(W)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] ram_model(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] sdat(int c, int k);
    return 32'hD000_0000 | 32'(c << 8) | 32'(k);
  endfunction
  assign bus.ramload = ram_model(bus.ramaddr);
  task automatic idle_all();
    bus.iREN = '0;
    bus.dREN = '0;
    bus.dWEN = '0;
    bus.cctrans = '0;
    bus.ccwrite = '0;
    bus.iaddr = '0;
    bus.daddr = '0;
    bus.dstore = '0;
    bus.ramstate = ACCESS;
    foreach (acc[j]) acc[j] = 0;
  endtask
  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.iwait !== 4'hF || bus.dwait !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_wait: iwait=%h dwait=%h want F F", bus.iwait, bus.dwait);
    end
    n_chk++;
    if ({bus.ccwait, bus.ccinv} !== 8'h00 || bus.ccsnoopaddr !== '0) begin
      n_fail++;
      $display("FAIL reset_snoop: ccwait=%h ccinv=%h ccsnoopaddr=%h want zeros", bus.ccwait, bus.ccinv, bus.ccsnoopaddr);
    end
    n_chk++;
    if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== '0 || bus.iload !== '0 || bus.dload !== '0) begin
      n_fail++;
      $display("FAIL reset_ram: REN=%b WEN=%b addr=%h store=%h want zeros", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_ifetch();
    exp_t e;
    @(posedge clk);
    #1;
    bus.iREN[2] = 1'b1;
    bus.iaddr[2] = 32'h100;
    exp_q.push_back('{2, 32'h100, ram_model(32'h100)});
    @(negedge clk);
    n_chk++;
    if (bus.iwait !== 4'hF || bus.ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL ifetch_early: iwait=%h ramREN=%b want F 0", bus.iwait, bus.ramREN);
    end
    @(negedge clk);
    n_chk++;
    if (bus.iwait !== 4'b1011) begin
      n_fail++;
      $display("FAIL ifetch_iwait: iwait=%h want b", bus.iwait);
    end
    e = exp_q.pop_front();
    n_chk++;
    if ({bus.ramREN, bus.ramaddr, bus.iload[e.core]} !== {1'b1, e.addr, e.data}) begin
      n_fail++;
      $display("FAIL ifetch_data: REN=%b addr=%h iload=%h want 1 %h %h", bus.ramREN, bus.ramaddr, bus.iload[e.core], e.addr, e.data);
    end
    @(posedge clk);
    #1 bus.iREN[2] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (dut.rr_ptr !== 2'd3 || bus.iwait !== 4'hF) begin
      n_fail++;
      $display("FAIL ifetch_rr: rr_ptr=%0d iwait=%h want 3 F", dut.rr_ptr, bus.iwait);
    end
  endtask
  task automatic test_rr_order();
    exp_t e;
    int cores [3] = '{0, 1, 3};
    int first = -1;
    logic [31:0] b;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    idle_all();
    for (int i = 0; i < 3; i++) begin
      b = 32'h1000 + 32'(cores[i] * 256);
      bus.dREN[cores[i]] = 1'b1;
      bus.daddr[cores[i]] = b + 32'h4;
      for (int k = 0; k < W; k++) exp_q.push_back('{cores[i], b + 32'(4 * k), ram_model(b + 32'(4 * k))});
    end
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) begin
        if (!bus.dwait[j]) begin
          acc[j]++;
          if (first < 0) first = cyc;
          e = exp_q.pop_front();
          n_chk++;
          if (j !== e.core || bus.ramREN !== 1'b1 || bus.ramaddr !== e.addr || bus.dload[j] !== e.data || bus.ccwait !== ~(4'b0001 << j)) begin
            n_fail++;
            $display("FAIL rd_word: core=%0d addr=%h dload=%h ccwait=%h want core=%0d addr=%h dload=%h", j, bus.ramaddr, bus.dload[j], bus.ccwait, e.core, e.addr, e.data);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int j = 0; j < N; j++) if (acc[j] == W) bus.dREN[j] = 1'b0;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_timeout: %0d words left want 0", exp_q.size());
      exp_q.delete();
    end
    n_chk++;
    if (first != 3) begin
      n_fail++;
      $display("FAIL rd_latency: first word at cycle %0d want 3", first);
    end
  endtask
  task automatic test_flush();
    exp_t e;
    idle_all();
    bus.dREN[1] = 1'b1;
    bus.cctrans[1] = 1'b1;
    bus.ccwrite[1] = 1'b1;
    bus.daddr[1] = 32'h2A4;
    bus.cctrans[3] = 1'b1;
    bus.dstore[3] = sdat(3, 0);
    for (int k = 0; k < W; k++) exp_q.push_back('{1, 32'h2A0 + 32'(4 * k), sdat(3, k)});
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_chk++;
        if (bus.ccinv !== 4'b1101 || bus.ccwait !== 4'b1101 || bus.ccsnoopaddr[0] !== 32'h2A0 || bus.ccsnoopaddr[2] !== 32'h2A0 || bus.ccsnoopaddr[3] !== 32'h2A0) begin
          n_fail++;
          $display("FAIL flush_snoop: ccinv=%h ccwait=%h snoopaddr=%h want d d 2a0", bus.ccinv, bus.ccwait, bus.ccsnoopaddr);
        end
      end
      if (!bus.dwait[1] || !bus.dwait[3]) begin
        acc[1]++;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.dwait !== 4'b0101 || bus.ramWEN !== 1'b1 || bus.ramaddr !== e.addr || bus.ramstore !== e.data || bus.dload[1] !== e.data || bus.ccsnoopaddr[3] !== e.addr) begin
          n_fail++;
          $display("FAIL flush_word: dwait=%h addr=%h store=%h dload=%h want 5 %h %h %h", bus.dwait, bus.ramaddr, bus.ramstore, bus.dload[1], e.addr, e.data, e.data);
        end
      end
      @(posedge clk);
      #1;
      if (acc[1] == W) idle_all();
      else bus.dstore[3] = sdat(3, acc[1]);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_timeout: %0d words left want 0", exp_q.size());
      exp_q.delete();
    end
    idle_all();
  endtask
  task automatic test_multi_resp();
    exp_t e;
    int d2 = 0;
    idle_all();
    bus.dREN[1] = 1'b1;
    bus.cctrans[1] = 1'b1;
    bus.daddr[1] = 32'h300;
    bus.cctrans[0] = 1'b1;
    bus.cctrans[2] = 1'b1;
    bus.dstore[0] = sdat(0, 0);
    bus.dstore[2] = sdat(2, 0);
    for (int k = 0; k < W; k++) exp_q.push_back('{1, 32'h300 + 32'(4 * k), sdat(0, k)});
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (!bus.dwait[2]) d2++;
      if (!bus.dwait[1]) begin
        acc[1]++;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.dwait[0] !== 1'b0 || bus.ramaddr !== e.addr || bus.ramstore !== e.data || bus.dload[1] !== e.data || bus.ccinv !== 4'h0) begin
          n_fail++;
          $display("FAIL multi_word: dwait=%h addr=%h store=%h ccinv=%h want 0 at [0] %h %h 0", bus.dwait, bus.ramaddr, bus.ramstore, bus.ccinv, e.addr, e.data);
        end
      end
      @(posedge clk);
      #1;
      if (acc[1] == W) idle_all();
      else begin
        bus.dstore[0] = sdat(0, acc[1]);
        bus.dstore[2] = sdat(2, acc[1]);
      end
    end
    n_chk++;
    if (exp_q.size() != 0 || d2 != 0) begin
      n_fail++;
      $display("FAIL multi_resp: left=%0d dwait2_pulses=%0d want 0 0", exp_q.size(), d2);
      exp_q.delete();
    end
    idle_all();
  endtask
  task automatic test_writeback_busy();
    exp_t e;
    int held = 0;
    idle_all();
    bus.dWEN[0] = 1'b1;
    bus.daddr[0] = 32'h40;
    bus.dstore[0] = sdat(0, 0);
    bus.ramstate = BUSY;
    for (int k = 0; k < W; k++) exp_q.push_back('{0, 32'h40 + 32'(4 * k), sdat(0, k)});
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (bus.ramstate == BUSY && bus.ramWEN && exp_q.size() > 0) begin
        held++;
        n_chk++;
        if (bus.dwait !== 4'hF || bus.ramaddr !== exp_q[0].addr) begin
          n_fail++;
          $display("FAIL wb_hold: dwait=%h addr=%h want f %h", bus.dwait, bus.ramaddr, exp_q[0].addr);
        end
      end
      if (!bus.dwait[0]) begin
        acc[0]++;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== e.addr || bus.ramstore !== e.data) begin
          n_fail++;
          $display("FAIL wb_word: WEN=%b addr=%h store=%h want 1 %h %h", bus.ramWEN, bus.ramaddr, bus.ramstore, e.addr, e.data);
        end
      end
      @(posedge clk);
      #1;
      bus.ramstate = bus.ramstate == BUSY ? ACCESS : BUSY;
      if (acc[0] == W) bus.dWEN[0] = 1'b0;
      else bus.dstore[0] = sdat(0, acc[0]);
    end
    n_chk++;
    if (exp_q.size() != 0 || held < W - 1) begin
      n_fail++;
      $display("FAIL wb_done: left=%0d busy_cycles=%0d want 0 >=%0d", exp_q.size(), held, W - 1);
      exp_q.delete();
    end
    idle_all();
  endtask
  task automatic test_reset_mid_flush();
    exp_t e;
    idle_all();
    bus.dREN[1] = 1'b1;
    bus.cctrans[1] = 1'b1;
    bus.daddr[1] = 32'h500;
    bus.cctrans[3] = 1'b1;
    bus.dstore[3] = sdat(3, 0);
    for (int cyc = 0; cyc < 20 && acc[1] < 2; cyc++) begin
      @(negedge clk);
      if (!bus.dwait[1]) acc[1]++;
      @(posedge clk);
      #1 bus.dstore[3] = sdat(3, acc[1]);
    end
    n_chk++;
    if (acc[1] != 2 || bus.ramaddr !== 32'h508 || bus.ramWEN !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_setup: words=%0d addr=%h WEN=%b want 2 508 1", acc[1], bus.ramaddr, bus.ramWEN);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.ramWEN, bus.ramREN, bus.dwait, bus.ccwait} !== {2'b00, 4'hF, 4'h0}) begin
      n_fail++;
      $display("FAIL rst_mid: WEN=%b REN=%b dwait=%h ccwait=%h want 0 0 f 0", bus.ramWEN, bus.ramREN, bus.dwait, bus.ccwait);
    end
    @(negedge clk);
    rst = 1'b0;
    acc[1] = 0;
    bus.dstore[3] = sdat(3, 0);
    for (int k = 0; k < W; k++) exp_q.push_back('{1, 32'h500 + 32'(4 * k), sdat(3, k)});
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (!bus.dwait[1]) begin
        acc[1]++;
        e = exp_q.pop_front();
        n_chk++;
        if (bus.dwait[3] !== 1'b0 || bus.ramaddr !== e.addr || bus.ramstore !== e.data || bus.dload[1] !== e.data) begin
          n_fail++;
          $display("FAIL rst_restart: dwait=%h addr=%h store=%h want 5 %h %h", bus.dwait, bus.ramaddr, bus.ramstore, e.addr, e.data);
        end
      end
      @(posedge clk);
      #1;
      if (acc[1] == W) idle_all();
      else bus.dstore[3] = sdat(3, acc[1]);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_timeout: %0d words left want 0", exp_q.size());
      exp_q.delete();
    end
    idle_all();
  endtask
  initial begin
    test_reset();
    test_ifetch();
    test_rr_order();
    test_flush();
    test_multi_resp();
    test_writeback_busy();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
